// File: rtl/insn_retire_counter.sv
// Retired-instruction counter with slow display snapshot
// and a synchronised, debounced display-enable switch.
module insn_retire_counter #(
  parameter int CNT_W           = 32,
  parameter int REFRESH_DIV     = 1_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int DISP_SHIFT      = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             insn_retired,
  input  logic             clear_count,
  input  logic             switch_raw,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic [15:0]      display_value,
  output logic             display_en
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    S_LOW,
    S_RISE,
    S_HIGH,
    S_FALL
  } state_t;

  logic [RW-1:0] refresh_cnt;
  logic          refresh_tick;
  logic          sync1;
  logic          sync2;
  logic [DW-1:0] db_cnt;
  logic          db_done;
  state_t        state;

  assign refresh_tick = refresh_cnt == RW'(REFRESH_DIV - 1);
  assign db_done      = db_cnt == DW'(DEBOUNCE_CYCLES - 1);

  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear_count) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (insn_retired) begin
      count <= count + CNT_W'(1);
      if (&count)
        overflow <= 1'b1;
    end
  end

  // Snapshot uses the pre-edge count, so a same-edge retire is not shown.
  always_ff @(posedge clock) begin
    if (reset || clear_count) begin
      refresh_cnt   <= '0;
      display_value <= '0;
    end else if (refresh_tick) begin
      refresh_cnt   <= '0;
      display_value <= count[DISP_SHIFT +: 16];
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= switch_raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_LOW;
      db_cnt     <= '0;
      display_en <= 1'b0;
    end else begin
      display_en <= (state == S_HIGH) || (state == S_FALL);
      unique case (state)
        S_LOW: begin
          if (sync2) begin
            state  <= S_RISE;
            db_cnt <= '0;
          end
        end
        S_RISE: begin
          if (!sync2)
            state <= S_LOW;
          else if (db_done)
            state <= S_HIGH;
          else
            db_cnt <= db_cnt + DW'(1);
        end
        S_HIGH: begin
          if (!sync2) begin
            state  <= S_FALL;
            db_cnt <= '0;
          end
        end
        S_FALL: begin
          if (sync2)
            state <= S_HIGH;
          else if (db_done)
            state <= S_LOW;
          else
            db_cnt <= db_cnt + DW'(1);
        end
        default: state <= S_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_insn_retire_counter.sv
// Directed bench for insn_retire_counter.
// Inputs change on negedge; outputs sampled on negedge.
module tb_insn_retire_counter;

  logic        clock;
  logic        reset;
  logic        insn_retired;
  logic        clear_count;
  logic        switch_raw;
  logic [15:0] count;
  logic        overflow;
  logic [15:0] display_value;
  logic        display_en;

  logic        insn2;
  logic        clear2;
  logic [31:0] count2;
  logic        overflow2;
  logic [15:0] display2;
  logic        en2;

  int n_chk;
  int n_bad;

  insn_retire_counter #(
    .CNT_W(16),
    .REFRESH_DIV(4),
    .DEBOUNCE_CYCLES(3),
    .DISP_SHIFT(0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .insn_retired(insn_retired),
    .clear_count(clear_count),
    .switch_raw(switch_raw),
    .count(count),
    .overflow(overflow),
    .display_value(display_value),
    .display_en(display_en)
  );

  insn_retire_counter #(
    .CNT_W(32),
    .REFRESH_DIV(4),
    .DEBOUNCE_CYCLES(3),
    .DISP_SHIFT(8)
  ) dut2 (
    .clock(clock),
    .reset(reset),
    .insn_retired(insn2),
    .clear_count(clear2),
    .switch_raw(1'b0),
    .count(count2),
    .overflow(overflow2),
    .display_value(display2),
    .display_en(en2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    n_chk        = 0;
    n_bad        = 0;
    reset        = 1'b1;
    insn_retired = 1'b1;
    clear_count  = 1'b0;
    switch_raw   = 1'b0;
    insn2        = 1'b1;
    clear2       = 1'b0;
    tick();
    tick();
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_disp", 32'(display_value), 32'h0);
    chk("rst_en", 32'(display_en), 32'h0);
    chk("rst_count2", count2, 32'h0);

    // count 10 retires with snapshots at edges 4 and 8
    reset = 1'b0;
    insn2 = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 4) chk("disp_e4", 32'(display_value), 32'h3);
      if (e == 8) chk("disp_e8", 32'(display_value), 32'h7);
    end
    chk("count10", 32'(count), 32'd10);

    // run up to all-ones and wrap
    repeat (65525) tick();
    chk("count_max", 32'(count), 32'hFFFF);
    chk("ovf_pre", 32'(overflow), 32'h0);
    tick();
    chk("count_wrap", 32'(count), 32'h0);
    chk("ovf_set", 32'(overflow), 32'h1);
    tick();
    chk("ovf_sticky", 32'(overflow), 32'h1);
    clear_count = 1'b1;
    tick();
    chk("clr_count", 32'(count), 32'h0);
    chk("clr_ovf", 32'(overflow), 32'h0);
    chk("clr_disp", 32'(display_value), 32'h0);
    clear_count  = 1'b0;
    insn_retired = 1'b0;

    // debounced rise, then fall
    switch_raw = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      tick();
      chk("en_rise", 32'(display_en), 32'(e >= 6));
    end
    switch_raw = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      tick();
      chk("en_fall", 32'(display_en), 32'(e < 6));
    end

    // short glitch is ignored
    switch_raw = 1'b1;
    tick();
    chk("glitch", 32'(display_en), 32'h0);
    tick();
    chk("glitch", 32'(display_en), 32'h0);
    switch_raw = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      chk("glitch", 32'(display_en), 32'h0);
    end

    // reset mid-debounce and mid-prescale
    switch_raw   = 1'b1;
    insn_retired = 1'b1;
    repeat (3) tick();
    chk("pre_rst_count", 32'(count), 32'd3);
    reset = 1'b1;
    tick();
    chk("mid_rst_count", 32'(count), 32'h0);
    chk("mid_rst_disp", 32'(display_value), 32'h0);
    chk("mid_rst_en", 32'(display_en), 32'h0);
    reset = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      tick();
      if (e == 2) chk("post_rst_disp", 32'(display_value), 32'h0);
      if (e == 3) chk("post_rst_disp", 32'(display_value), 32'h3);
      if (e == 5) chk("post_rst_en", 32'(display_en), 32'h0);
      if (e == 6) chk("post_rst_en", 32'(display_en), 32'h1);
    end
    insn_retired = 1'b0;
    switch_raw   = 1'b0;

    // shifted window on a 32-bit counter
    insn2 = 1'b1;
    repeat (767) tick();
    chk("c2_pre", count2, 32'h2FF);
    tick();
    insn2 = 1'b0;
    chk("c2_post", count2, 32'h300);
    repeat (4) tick();
    chk("c2_disp", 32'(display2), 32'h3);
    chk("c2_ovf", 32'(overflow2), 32'h0);
    chk("c2_en", 32'(en2), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
